// File: rtl/dma_mm2s_sequencer.sv
// AXI4-Lite master that programs one AXI DMA MM2S simple-mode transfer per start,
// waits for the interrupt, reads and clears DMASR, then reports done plus an error code.
module dma_mm2s_sequencer #(
    parameter int          LEN_W       = 26,
    parameter int          TIMEOUT_CYC = 0,
    parameter logic [31:0] DMACR_VAL   = 32'h0000_5001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] dest_addr,
    input  logic [31:0] byte_num,
    input  logic        mm2s_introut,
    output logic        busy,
    output logic        done,
    output logic [2:0]  err_code,
    output logic [31:0] dma_status,
    output logic [9:0]  m_axi_lite_awaddr,
    output logic        m_axi_lite_awvalid,
    input  logic        m_axi_lite_awready,
    output logic [31:0] m_axi_lite_wdata,
    output logic        m_axi_lite_wvalid,
    input  logic        m_axi_lite_wready,
    input  logic [1:0]  m_axi_lite_bresp,
    input  logic        m_axi_lite_bvalid,
    output logic        m_axi_lite_bready,
    output logic [9:0]  m_axi_lite_araddr,
    output logic        m_axi_lite_arvalid,
    input  logic        m_axi_lite_arready,
    input  logic [31:0] m_axi_lite_rdata,
    input  logic [1:0]  m_axi_lite_rresp,
    input  logic        m_axi_lite_rvalid,
    output logic        m_axi_lite_rready
);

    // Handshakes: a transfer completes on a rising clk edge where valid and ready are both 1;
    // valid, address and data are held stable while valid=1 and ready=0.
    typedef enum logic [3:0] {
        S_IDLE, S_WR_CR, S_WR_SA, S_WR_MSB, S_WR_LEN,
        S_WAIT_IRQ, S_RD_SR, S_WR_SR, S_DONE
    } state_t;

    localparam logic [32:0] LEN_LIMIT = 33'd1 << LEN_W;
    localparam logic [31:0] TO_LAST   = (TIMEOUT_CYC > 0) ? 32'(TIMEOUT_CYC - 1) : 32'd0;

    state_t      state, state_n;
    logic        awvalid_q, wvalid_q, arvalid_q;
    logic [2:0]  err_q, err_n;
    logic [31:0] status_q, status_n;
    logic [63:0] addr_q, addr_n;
    logic [31:0] len_q, len_n;
    logic [31:0] cnt_q, cnt_n;
    logic        is_wr, b_done, r_done, enter_wr, enter_rd;

    always_comb begin
        is_wr             = 1'b1;
        m_axi_lite_awaddr = 10'h000;
        m_axi_lite_wdata  = 32'h0;
        case (state)
            S_WR_CR:  m_axi_lite_wdata = DMACR_VAL;
            S_WR_SA:  begin m_axi_lite_awaddr = 10'h018; m_axi_lite_wdata = addr_q[31:0];  end
            S_WR_MSB: begin m_axi_lite_awaddr = 10'h01C; m_axi_lite_wdata = addr_q[63:32]; end
            S_WR_LEN: begin m_axi_lite_awaddr = 10'h028; m_axi_lite_wdata = len_q;         end
            S_WR_SR:  begin m_axi_lite_awaddr = 10'h004; m_axi_lite_wdata = 32'h0000_5000; end
            default:  is_wr = 1'b0;
        endcase
    end

    // bready only after both the address and data phases have been accepted
    assign m_axi_lite_bready  = is_wr && !awvalid_q && !wvalid_q;
    assign m_axi_lite_rready  = (state == S_RD_SR) && !arvalid_q;
    assign m_axi_lite_araddr  = (state == S_RD_SR) ? 10'h004 : 10'h000;
    assign m_axi_lite_awvalid = awvalid_q;
    assign m_axi_lite_wvalid  = wvalid_q;
    assign m_axi_lite_arvalid = arvalid_q;
    assign b_done     = m_axi_lite_bready && m_axi_lite_bvalid;
    assign r_done     = m_axi_lite_rready && m_axi_lite_rvalid;
    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE);
    assign err_code   = err_q;
    assign dma_status = status_q;

    always_comb begin
        state_n  = state;
        err_n    = err_q;
        status_n = status_q;
        addr_n   = addr_q;
        len_n    = len_q;
        cnt_n    = cnt_q;
        case (state)
            S_IDLE: begin
                if (start) begin
                    addr_n = dest_addr;
                    len_n  = byte_num;
                    err_n  = 3'd0;
                    if ((byte_num == 32'd0) || ({1'b0, byte_num} >= LEN_LIMIT)) begin
                        err_n   = 3'd1;
                        state_n = S_DONE;
                    end else begin
                        state_n = S_WR_CR;
                    end
                end
            end
            S_WR_CR, S_WR_SA, S_WR_MSB, S_WR_LEN, S_WR_SR: begin
                if (b_done) begin
                    if (m_axi_lite_bresp != 2'b00) begin
                        // a DMASR error already reported outranks a failed clear
                        if ((state != S_WR_SR) || (err_q == 3'd0)) err_n = 3'd2;
                        state_n = S_DONE;
                    end else begin
                        case (state)
                            S_WR_CR:  state_n = S_WR_SA;
                            S_WR_SA:  state_n = S_WR_MSB;
                            S_WR_MSB: state_n = S_WR_LEN;
                            S_WR_LEN: begin state_n = S_WAIT_IRQ; cnt_n = 32'd0; end
                            default:  state_n = S_DONE;
                        endcase
                    end
                end
            end
            S_WAIT_IRQ: begin
                if (mm2s_introut) begin
                    state_n = S_RD_SR;
                end else if (TIMEOUT_CYC > 0) begin
                    if (cnt_q == TO_LAST) begin
                        err_n   = 3'd5;
                        state_n = S_DONE;
                    end else begin
                        cnt_n = cnt_q + 32'd1;
                    end
                end
            end
            S_RD_SR: begin
                if (r_done) begin
                    status_n = m_axi_lite_rdata;
                    if (m_axi_lite_rresp != 2'b00) begin
                        err_n   = 3'd3;
                        state_n = S_DONE;
                    end else begin
                        if (m_axi_lite_rdata[6:4] != 3'b000) err_n = 3'd4;
                        state_n = S_WR_SR;
                    end
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    assign enter_wr = (state_n != state) &&
                      (state_n inside {S_WR_CR, S_WR_SA, S_WR_MSB, S_WR_LEN, S_WR_SR});
    assign enter_rd = (state_n != state) && (state_n == S_RD_SR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            err_q     <= 3'd0;
            status_q  <= 32'h0;
            addr_q    <= 64'h0;
            len_q     <= 32'h0;
            cnt_q     <= 32'h0;
        end else begin
            state     <= state_n;
            awvalid_q <= enter_wr || (awvalid_q && !m_axi_lite_awready);
            wvalid_q  <= enter_wr || (wvalid_q && !m_axi_lite_wready);
            arvalid_q <= enter_rd || (arvalid_q && !m_axi_lite_arready);
            err_q     <= err_n;
            status_q  <= status_n;
            addr_q    <= addr_n;
            len_q     <= len_n;
            cnt_q     <= cnt_n;
        end
    end

endmodule

// File: tb/tb_dma_mm2s_sequencer.sv
// Self-checking bench for dma_mm2s_sequencer: AXI-Lite slave model with a write scoreboard
// and one task per scenario.
module tb_dma_mm2s_sequencer;
    localparam int TO = 100;

    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, introut = 1'b0;
    logic [63:0] dest_addr = 64'h0;
    logic [31:0] byte_num = 32'h0;
    logic        busy, done;
    logic [2:0]  err_code;
    logic [31:0] dma_status;
    logic [9:0]  awaddr, araddr;
    logic [31:0] wdata;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
    logic [1:0]  bresp = 2'b00, rresp = 2'b00;
    logic [31:0] rdata = 32'h0;

    dma_mm2s_sequencer #(.LEN_W(26), .TIMEOUT_CYC(TO), .DMACR_VAL(32'h0000_5001)) dut (
        .clk(clk), .rst(rst), .start(start), .dest_addr(dest_addr), .byte_num(byte_num),
        .mm2s_introut(introut), .busy(busy), .done(done), .err_code(err_code),
        .dma_status(dma_status),
        .m_axi_lite_awaddr(awaddr), .m_axi_lite_awvalid(awvalid), .m_axi_lite_awready(awready),
        .m_axi_lite_wdata(wdata), .m_axi_lite_wvalid(wvalid), .m_axi_lite_wready(wready),
        .m_axi_lite_bresp(bresp), .m_axi_lite_bvalid(bvalid), .m_axi_lite_bready(bready),
        .m_axi_lite_araddr(araddr), .m_axi_lite_arvalid(arvalid), .m_axi_lite_arready(arready),
        .m_axi_lite_rdata(rdata), .m_axi_lite_rresp(rresp), .m_axi_lite_rvalid(rvalid),
        .m_axi_lite_rready(rready)
    );

    // clock / reset
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, fails = 0;
    logic [41:0] exp_q[$];

    int          aw_delay = 0, w_delay = 0;
    logic [1:0]  bresp_plan [8];
    logic [31:0] sr_value = 32'h0000_1000;
    logic [1:0]  rresp_val = 2'b00;
    int          writes_seen = 0, reads_seen = 0, aw_cycles = 0, bready_rises = 0, stab_err = 0;
    int          len_b_cyc = 0;
    bit          aw_alone = 1'b0, w_alone = 1'b0;

    // AXI-Lite slave model and write scoreboard
    initial begin : slave
        int aw_cnt, w_cnt, ar_cnt;
        bit got_aw, got_w, got_ar, aw_hs, w_hs, b_hs, ar_hs, r_hs;
        bit prev_aw_wait, prev_w_wait, prev_bready;
        logic [9:0]  cap_addr, prev_awaddr;
        logic [31:0] cap_data, prev_wdata;
        logic [41:0] exp;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
        got_aw = 0; got_w = 0; got_ar = 0;
        prev_aw_wait = 0; prev_w_wait = 0; prev_bready = 0;
        cap_addr = '0; cap_data = '0; prev_awaddr = '0; prev_wdata = '0;
        forever begin
            @(negedge clk);
            aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
            if (!rst) begin
                aw_hs = awvalid && awready;
                w_hs  = wvalid && wready;
                b_hs  = bvalid && bready;
                ar_hs = arvalid && arready;
                r_hs  = rvalid && rready;
                if (prev_aw_wait && (!awvalid || awaddr !== prev_awaddr)) stab_err++;
                if (prev_w_wait && (!wvalid || wdata !== prev_wdata)) stab_err++;
                prev_aw_wait = awvalid && !awready; prev_awaddr = awaddr;
                prev_w_wait  = wvalid && !wready;   prev_wdata  = wdata;
                if (awvalid) aw_cycles++;
                if (awvalid && !wvalid) aw_alone = 1'b1;
                if (wvalid && !awvalid) w_alone = 1'b1;
                if (bready && !prev_bready) bready_rises++;
                prev_bready = bready;
                if (aw_hs) begin cap_addr = awaddr; got_aw = 1; end
                if (w_hs) begin cap_data = wdata; got_w = 1; end
                if (b_hs) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL write_unexpected: got addr=%h data=%h, required no write",
                                 cap_addr, cap_data);
                    end else begin
                        exp = exp_q.pop_front();
                        if ({cap_addr, cap_data} !== exp) begin
                            fails++;
                            $display("FAIL write_seq: got addr=%h data=%h, required addr=%h data=%h",
                                     cap_addr, cap_data, exp[41:32], exp[31:0]);
                        end
                    end
                    if (cap_addr == 10'h028) len_b_cyc = cyc + 1;
                    if (cap_addr == 10'h004) introut = 1'b0;
                    writes_seen++;
                    got_aw = 0; got_w = 0;
                end
                if (ar_hs) begin
                    checks++;
                    if (araddr !== 10'h004) begin
                        fails++;
                        $display("FAIL araddr: got %h, required 004", araddr);
                    end
                    got_ar = 1;
                end
                if (r_hs) reads_seen++;
            end else begin
                prev_aw_wait = 0; prev_w_wait = 0; prev_bready = 0;
                got_aw = 0; got_w = 0; got_ar = 0;
            end
            @(posedge clk);
            #1;
            if (rst) begin
                awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
                aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
            end else begin
                if (!awvalid) begin aw_cnt = 0; awready = 0; end
                else begin awready = (aw_cnt >= aw_delay); aw_cnt++; end
                if (!wvalid) begin w_cnt = 0; wready = 0; end
                else begin wready = (w_cnt >= w_delay); w_cnt++; end
                if (!arvalid) begin ar_cnt = 0; arready = 0; end
                else begin arready = 1'b1; ar_cnt++; end
                if (b_hs) bvalid = 0;
                else if (got_aw && got_w && !bvalid) begin
                    bvalid = 1;
                    bresp  = (writes_seen < 8) ? bresp_plan[writes_seen] : 2'b00;
                end
                if (r_hs) begin rvalid = 0; got_ar = 0; end
                else if (got_ar && !rvalid) begin rvalid = 1; rdata = sr_value; rresp = rresp_val; end
            end
        end
    end

    // driver tasks
    task automatic cfg(input int awd, input int wd);
        aw_delay = awd; w_delay = wd;
        for (int i = 0; i < 8; i++) bresp_plan[i] = 2'b00;
        sr_value = 32'h0000_1000; rresp_val = 2'b00;
        exp_q.delete();
        writes_seen = 0; reads_seen = 0; aw_cycles = 0; bready_rises = 0; stab_err = 0;
        len_b_cyc = 0; aw_alone = 0; w_alone = 0; introut = 0;
    endtask

    task automatic push_seq(input logic [63:0] a, input logic [31:0] n, input int count);
        logic [41:0] seq [5];
        seq[0] = {10'h000, 32'h0000_5001};
        seq[1] = {10'h018, a[31:0]};
        seq[2] = {10'h01C, a[63:32]};
        seq[3] = {10'h028, n};
        seq[4] = {10'h004, 32'h0000_5000};
        for (int i = 0; i < count; i++) exp_q.push_back(seq[i]);
    endtask

    task automatic do_start(input logic [63:0] a, input logic [31:0] n);
        @(negedge clk);
        dest_addr = a; byte_num = n; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, output int cycles, output bit seen);
        cycles = 0; seen = done;
        while (!seen && cycles < max_cyc) begin
            @(negedge clk);
            cycles++;
            seen = done;
        end
    endtask

    task automatic wait_writes(input int n, input int max_cyc, output bit ok);
        ok = 0;
        for (int i = 0; i < max_cyc; i++) begin
            if (writes_seen >= n) begin ok = 1; break; end
            @(negedge clk);
        end
    endtask

    // scenarios
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, awvalid, wvalid, bready, arvalid, rready} !== 7'b0) begin
            fails++;
            $display("FAIL reset_ctrl: got %b, required 0000000",
                     {busy, done, awvalid, wvalid, bready, arvalid, rready});
        end
        checks++;
        if (err_code !== 3'd0 || dma_status !== 32'h0) begin
            fails++;
            $display("FAIL reset_status: got err=%0d status=%h, required 0/0", err_code, dma_status);
        end
        checks++;
        if (awaddr !== 10'h0 || araddr !== 10'h0 || wdata !== 32'h0) begin
            fails++;
            $display("FAIL reset_bus: got aw=%h ar=%h wd=%h, required 0", awaddr, araddr, wdata);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_full();
        int c; bit s, ok;
        cfg(0, 0);
        push_seq(64'h0000_0001_8000_0000, 32'd4096, 5);
        do_start(64'h0000_0001_8000_0000, 32'd4096);
        checks++;
        if (busy !== 1'b1) begin fails++; $display("FAIL full_busy: got %b, required 1", busy); end
        wait_writes(4, 200, ok);
        checks++;
        if (!ok) begin fails++; $display("FAIL full_writes4: got %0d writes, required 4", writes_seen); end
        do_start(64'h0000_0002_0000_0000, 32'd16);
        introut = 1'b1;
        wait_done(200, c, s);
        checks++;
        if (!s) begin fails++; $display("FAIL full_done: got no done, required done"); end
        checks++;
        if (err_code !== 3'd0 || dma_status !== 32'h0000_1000) begin
            fails++;
            $display("FAIL full_result: got err=%0d status=%h, required 0/00001000", err_code, dma_status);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL full_pulse: got done=%b busy=%b, required 0/0", done, busy);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || writes_seen != 5 || reads_seen != 1 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL full_counts: got busy=%b w=%0d r=%0d left=%0d, required 0/5/1/0",
                     busy, writes_seen, reads_seen, exp_q.size());
        end
    endtask

    task automatic test_bad_len(input logic [31:0] n);
        int c; bit s;
        cfg(0, 0);
        do_start(64'h0000_0000_1000_0000, n);
        wait_done(4, c, s);
        checks++;
        if (!s || c > 1) begin
            fails++;
            $display("FAIL badlen_latency: got seen=%b cycles=%0d, required seen=1 cycles<=1", s, c);
        end
        checks++;
        if (err_code !== 3'd1) begin fails++; $display("FAIL badlen_err: got %0d, required 1", err_code); end
        repeat (2) @(negedge clk);
        checks++;
        if (aw_cycles != 0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL badlen_traffic: got aw_cycles=%0d busy=%b, required 0/0", aw_cycles, busy);
        end
    endtask

    task automatic test_handshake(input int awd, input int wd);
        int c; bit s, ok;
        cfg(awd, wd);
        push_seq(64'h1234_5678_9ABC_DEF0, 32'h03FF_FFFF, 5);
        do_start(64'h1234_5678_9ABC_DEF0, 32'h03FF_FFFF);
        wait_writes(4, 400, ok);
        introut = 1'b1;
        wait_done(400, c, s);
        checks++;
        if (!s || err_code !== 3'd0) begin
            fails++;
            $display("FAIL hs_done: got seen=%b err=%0d, required 1/0", s, err_code);
        end
        checks++;
        if (bready_rises != 5 || stab_err != 0) begin
            fails++;
            $display("FAIL hs_phases: got bready_phases=%0d unstable=%0d, required 5/0",
                     bready_rises, stab_err);
        end
        checks++;
        if ((awd > wd) ? !aw_alone : !w_alone) begin
            fails++;
            $display("FAIL hs_independent: got aw_alone=%b w_alone=%b, required late valid held alone",
                     aw_alone, w_alone);
        end
        checks++;
        if (exp_q.size() != 0) begin fails++; $display("FAIL hs_left: got %0d, required 0", exp_q.size()); end
    endtask

    task automatic test_bresp_err();
        int c; bit s;
        cfg(0, 0);
        bresp_plan[1] = 2'b10;
        push_seq(64'h0000_0001_8000_0000, 32'd4096, 2);
        do_start(64'h0000_0001_8000_0000, 32'd4096);
        wait_done(200, c, s);
        checks++;
        if (!s || err_code !== 3'd2) begin
            fails++;
            $display("FAIL bresp_err: got seen=%b err=%0d, required 1/2", s, err_code);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (writes_seen != 2 || reads_seen != 0 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL bresp_traffic: got w=%0d r=%0d left=%0d, required 2/0/0",
                     writes_seen, reads_seen, exp_q.size());
        end
    endtask

    task automatic test_timeout();
        int c; bit s;
        cfg(0, 0);
        push_seq(64'h0000_0000_4000_0000, 32'd256, 4);
        do_start(64'h0000_0000_4000_0000, 32'd256);
        wait_done(400, c, s);
        checks++;
        if (!s || err_code !== 3'd5) begin
            fails++;
            $display("FAIL timeout_err: got seen=%b err=%0d, required 1/5", s, err_code);
        end
        checks++;
        if (cyc - len_b_cyc != TO) begin
            fails++;
            $display("FAIL timeout_latency: got %0d cycles, required %0d", cyc - len_b_cyc, TO);
        end
        checks++;
        if (writes_seen != 4 || reads_seen != 0 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL timeout_traffic: got w=%0d r=%0d left=%0d, required 4/0/0",
                     writes_seen, reads_seen, exp_q.size());
        end
    endtask

    task automatic test_dmasr_err();
        int c; bit s, ok;
        cfg(0, 0);
        sr_value = 32'h0000_4011;
        push_seq(64'h0000_0003_0000_1000, 32'd64, 5);
        do_start(64'h0000_0003_0000_1000, 32'd64);
        wait_writes(4, 200, ok);
        repeat ($urandom_range(1, 5)) @(negedge clk);
        introut = 1'b1;
        wait_done(200, c, s);
        checks++;
        if (!s || err_code !== 3'd4 || dma_status !== 32'h0000_4011) begin
            fails++;
            $display("FAIL dmasr_err: got seen=%b err=%0d status=%h, required 1/4/00004011",
                     s, err_code, dma_status);
        end
        checks++;
        if (writes_seen != 5 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL dmasr_clear: got w=%0d left=%0d, required 5/0", writes_seen, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int c; bit s, ok;
        cfg(2, 2);
        push_seq(64'h0000_0000_2000_0000, 32'd512, 5);
        do_start(64'h0000_0000_2000_0000, 32'd512);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            if (awvalid && awaddr == 10'h028) begin ok = 1; break; end
            @(negedge clk);
        end
        checks++;
        if (!ok) begin fails++; $display("FAIL rstmid_reach: got no LENGTH write, required one"); end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, awvalid, wvalid, bready, arvalid, rready} !== 7'b0 || err_code !== 3'd0) begin
            fails++;
            $display("FAIL rstmid_outputs: got ctrl=%b err=%0d, required 0/0",
                     {busy, done, awvalid, wvalid, bready, arvalid, rready}, err_code);
        end
        rst = 1'b0;
        @(negedge clk);
        cfg(0, 0);
        push_seq(64'h0000_0000_2000_0000, 32'd512, 5);
        do_start(64'h0000_0000_2000_0000, 32'd512);
        wait_writes(4, 200, ok);
        introut = 1'b1;
        wait_done(200, c, s);
        checks++;
        if (!s || err_code !== 3'd0 || writes_seen != 5 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL rstmid_rerun: got seen=%b err=%0d w=%0d left=%0d, required 1/0/5/0",
                     s, err_code, writes_seen, exp_q.size());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 8; i++) bresp_plan[i] = 2'b00;
        test_reset();
        test_full();
        test_bad_len(32'd0);
        test_bad_len(32'h0400_0000);
        test_handshake(3, 0);
        test_handshake(0, 3);
        test_bresp_err();
        test_timeout();
        test_dmasr_err();
        test_reset_mid();
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
